// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
// The master side (control unit) drives the request and operands; the
// slave side (divider) returns status and results.
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Each iteration performs a trial subtraction (A + ~B + 1) of the divisor
// from the shifted partial remainder; the borrow selects the quotient bit
// and whether the remainder is restored.
// Optional build macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands with
// truncating division (magnitudes divided, signs applied on entering DONE).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Trial subtraction a - b as a + ~b + 1, one bit wider so the MSB is the borrow.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        trial_sub = {1'b0, a} + ~{1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        negate = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude as an unsigned value; the most-negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        magnitude = x[WIDTH-1] ? negate(x) : x;
    endfunction
`endif

    state_t           state_r, state_s;
    logic [WIDTH-1:0] r_r, r_s;          // partial remainder
    logic [WIDTH-1:0] q_r, q_s;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_r, dvs_s;      // captured divisor (magnitude)
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH-1:0] quotient_r, quotient_s;
    logic [WIDTH-1:0] remainder_r, remainder_s;
    logic             dbz_r, dbz_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             q_neg_r, q_neg_s;
    logic             r_neg_r, r_neg_s;
`endif

    logic [WIDTH-1:0] shift_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH-1:0] r_iter_s;
    logic [WIDTH-1:0] q_iter_s;

    // The remainder MSB is always clear before the last shift, so dropping it loses nothing.
    assign shift_s  = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
    assign trial_s  = trial_sub(shift_s, dvs_r);
    assign borrow_s = trial_s[WIDTH];
    assign r_iter_s = borrow_s ? shift_s : trial_s[WIDTH-1:0];
    assign q_iter_s = {q_r[WIDTH-2:0], ~borrow_s};

    // Next-state, datapath and output decode; defaults hold every register.
    always_comb begin
        state_s     = state_r;
        r_s         = r_r;
        q_s         = q_r;
        dvs_s       = dvs_r;
        count_s     = count_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_s     = q_neg_r;
        r_neg_s     = r_neg_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        // Divide by zero resolves immediately without iterating.
                        state_s     = ST_DONE;
                        quotient_s  = {WIDTH{1'b1}};
                        remainder_s = bus.dividend;
                        dbz_s       = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        r_s     = {WIDTH{1'b0}};
                        count_s = CNT_INIT;
                        dbz_s   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_s     = magnitude(bus.dividend);
                        dvs_s   = magnitude(bus.divisor);
                        q_neg_s = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_neg_s = bus.dividend[WIDTH-1];
`else
                        q_s     = bus.dividend;
                        dvs_s   = bus.divisor;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_s = r_iter_s;
                q_s = q_iter_s;
                if (count_r == CNT_ZERO) begin
                    state_s = ST_DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quotient_s  = q_neg_r ? negate(q_iter_s) : q_iter_s;
                    remainder_s = r_neg_r ? negate(r_iter_s) : r_iter_s;
`else
                    quotient_s  = q_iter_s;
                    remainder_s = r_iter_s;
`endif
                end else begin
                    count_s = count_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r         <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            count_r     <= CNT_ZERO;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_r         <= r_s;
            q_r         <= q_s;
            dvs_r       <= dvs_s;
            count_r     <= count_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_r     <= q_neg_s;
            r_neg_r     <= r_neg_s;
`endif
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=4): vector table plus
// hand-written sequences for back-to-back, ignored start and mid-run reset.
module tb_seq_divider;

    localparam int W = 4;
    localparam int MAX_WAIT = 20;

    logic clk;
    logic reset;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one start, scramble operands after capture, wait (bounded) for done.
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int lat, output int busy_cnt);
        bit got;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && lat < MAX_WAIT) begin
            tick();
            if (lat == 0) begin
                bus.start    = 1'b0;
                bus.dividend = ~a;
                bus.divisor  = a;
            end
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz, input int lat, input int busy_cnt);
        int exp_lat;
        exp_lat = dbz ? 1 : W + 1;
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " busy cycles"}, busy_cnt, dbz ? 0 : W);
        check({nm, " quotient"}, bus.quotient, q);
        check({nm, " remainder"}, bus.remainder, r);
        check({nm, " div_by_zero"}, bus.div_by_zero, dbz);
    endtask

    initial begin
        int lat;
        int bc;
        bit saw_done;

`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs.push_back('{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0}); // -7/2
        vecs.push_back('{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0}); // -8/-1
        vecs.push_back('{4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0}); // 7/-2
        vecs.push_back('{4'b1010, 4'b1101, 4'b0010, 4'b0000, 1'b0}); // -6/-3
        vecs.push_back('{4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1}); // 5/0
        vecs.push_back('{4'b1000, 4'b0011, 4'b1110, 4'b1110, 1'b0}); // -8/3
`else
        vecs.push_back('{4'd13, 4'd4,  4'd3,  4'd1, 1'b0});
        vecs.push_back('{4'd9,  4'd0,  4'd15, 4'd9, 1'b1});
        vecs.push_back('{4'd14, 4'd3,  4'd4,  4'd2, 1'b0});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0});
        vecs.push_back('{4'd7,  4'd9,  4'd0,  4'd7, 1'b0});
        vecs.push_back('{4'd15, 4'd2,  4'd7,  4'd1, 1'b0});
        vecs.push_back('{4'd12, 4'd5,  4'd2,  4'd2, 1'b0});
        vecs.push_back('{4'd1,  4'd1,  4'd1,  4'd0, 1'b0});
        vecs.push_back('{4'd0,  4'd0,  4'd15, 4'd0, 1'b1});
`endif

        clk = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor = 4'd0;
        tick();
        tick();
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset quotient", bus.quotient, 4'd0);
        check("reset remainder", bus.remainder, 4'd0);
        check("reset div_by_zero", bus.div_by_zero, 1'b0);
        reset = 1'b0;
        tick();

        // Table-driven vectors, each followed by a hold/single-pulse check.
        foreach (vecs[i]) begin
            start_and_wait(vecs[i].a, vecs[i].b, lat, bc);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, lat, bc);
            tick();
            check($sformatf("vec%0d done pulse", i), bus.done, 1'b0);
            check($sformatf("vec%0d hold quotient", i), bus.quotient, vecs[i].q);
            check($sformatf("vec%0d hold div_by_zero", i), bus.div_by_zero, vecs[i].dbz);
        end

        // Back-to-back: second start issued in the DONE cycle of the first.
        start_and_wait(4'd15, 4'd1, lat, bc);
        check_result("b2b first", 4'b1111, 4'b0000, 1'b0, lat, bc);
        start_and_wait(4'd0, 4'd7, lat, bc);
        check_result("b2b second", 4'b0000, 4'b0000, 1'b0, lat, bc);
        tick();

        // Start pulsed mid-run is ignored.
        bus.dividend = 4'd14;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.dividend = 4'd2;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        check("ignore latency", lat, W + 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check("ignore quotient", bus.quotient, 4'b0000);
        check("ignore remainder", bus.remainder, 4'b1110);
`else
        check("ignore quotient", bus.quotient, 4'b0100);
        check("ignore remainder", bus.remainder, 4'b0010);
`endif
        tick();
        check("ignore no restart", bus.busy, 1'b0);

        // Reset during RUN: immediate return to reset values, no done.
        bus.dividend = 4'd11;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset done", bus.done, 1'b0);
        check("mid reset quotient", bus.quotient, 4'd0);
        check("mid reset remainder", bus.remainder, 4'd0);
        check("mid reset div_by_zero", bus.div_by_zero, 1'b0);
        saw_done = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("mid reset stays idle", saw_done, 1'b0);
        start_and_wait(4'd11, 4'd2, lat, bc);
`ifdef SEQ_DIVIDER_SIGNED_EN
        check_result("after reset", 4'b1110, 4'b1111, 1'b0, lat, bc);
`else
        check_result("after reset", 4'b0101, 4'b0001, 1'b0, lat, bc);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
